alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; legal range 2 to 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream adder/subtractor result valid this cycle.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 in_sub  input  1  operation flag: 1 = subtract, 0 = add; stored with the entry.
REQ-007 in_s  input  WIDTH  raw sum/difference from the adder/subtractor.
REQ-008 in_carry  input  1  carry-out of the MSB; for subtract, 1 = no borrow.
REQ-009 in_overflow  input  1  signed overflow, i.e. carry into MSB XOR carry out of MSB.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream accepts the head entry.
REQ-012 out_result  output  WIDTH  head result, after saturation when enabled.
REQ-013 out_flags  output  4  head flags {N, Z, C, V}: N = result MSB, Z = result all-zero, C = stored carry, V = stored overflow.
REQ-014 out_sub  output  1  head entry operation flag.
REQ-015 clr_sticky  input  1  synchronous clear of sticky_v.
REQ-016 sticky_v  output  1  set once any accepted entry had overflow = 1.

Function
REQ-017 The stage SHALL be a 2-entry FIFO with transfer in on in_valid and in_ready both high, and transfer out on out_valid and out_ready both high.
REQ-018 in_ready SHALL be 1 when fewer than 2 entries are stored; it is a function of registered count only and never depends on out_ready.
REQ-019 out_valid SHALL be 1 when count is not 0; the outputs are driven from the head register with no combinational path from in_* to out_*.
REQ-020 Latency SHALL be 1 cycle: an entry accepted at edge k is visible on out_* after edge k when the FIFO was empty.
REQ-021 Count 0 with a push: count goes to 1.
REQ-022 Count 1, push and pop in the same cycle: count stays 1, the new entry becomes head, and order is preserved.
REQ-023 Count 2: no push (in_ready = 0); a pop moves the tail to the head and sets count to 1.
REQ-024 Read and write pointers SHALL be 1 bit each and wrap modulo 2.
REQ-025 Z and N SHALL be computed from the stored result after saturation; C and V SHALL be the raw stored in_carry and in_overflow.
REQ-026 While out_valid = 1 and out_ready = 0, out_result, out_flags and out_sub SHALL hold stable.
REQ-027 sticky_v update priority:
- accepted entry with in_overflow = 1 sets sticky_v;
- otherwise clr_sticky = 1 clears it;
- set wins over clear in the same cycle.
REQ-028 When count is 0, out_result and out_flags SHALL hold their last value; the value is don't-care.

Reset
REQ-029 While rst_n = 0, the stage SHALL hold:
- count = 0, pointers = 0, out_valid = 0, in_ready = 0, sticky_v = 0;
- all stored results, flags and out_sub = 0.
REQ-030 in_ready SHALL rise only on the first clock edge after rst_n deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard all stored entries with no partial output.

Configuration
REQ-032 Macro ALU_SATURATE_EN:
- when defined, an entry accepted with in_overflow = 1 SHALL store the saturated value instead of in_s;
- saturated value: in_s MSB = 1 gives 0111..1 (max positive), in_s MSB = 0 gives 1000..0 (min negative);
- when undefined, in_s is always stored unchanged.
- In both builds, V reports the raw overflow.

Verification (WIDTH = 4)
REQ-033 Add 0011 + 0100, in_s = 0111, carry = 0, ovf = 0, out_ready = 1 -> next cycle out_result = 0111, flags {N,Z,C,V} = 0000, sticky_v = 0.
REQ-034 Add 0111 + 0001, in_s = 1000, carry = 0, ovf = 1 -> without the macro out_result = 1000, flags = 1001; with the macro out_result = 0111, flags = 0001; in both builds sticky_v = 1.
REQ-035 Subtract 0101 - 0101, in_s = 0000, carry = 1, ovf = 0, in_sub = 1 -> out_result = 0000, flags = 0110, out_sub = 1.
REQ-036 Hold out_ready = 0 and push three results A, B, C on consecutive cycles -> A and B accepted, in_ready = 0 on the third cycle, C is held upstream; releasing out_ready gives outputs in order A, B, C.
REQ-037 Count = 1, push and pop in the same cycle, repeated 10 times -> count stays 1 and no entry is lost or duplicated; then pulse clr_sticky together with an ovf = 1 push -> sticky_v = 1.
REQ-038 With 2 entries stored, assert rst_n = 0 asynchronously between edges -> out_valid = 0 and sticky_v = 0 immediately; after release, the first in_valid is accepted one edge later.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the adder/subtractor, the result stage
// and its consumer.
interface alu_result_stage_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [WIDTH-1:0] in_s;
  logic             in_carry;
  logic             in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic             out_sub;

  modport master (
    output in_valid, in_sub, in_s, in_carry,
    output in_overflow, out_ready,
    input  in_ready, out_valid, out_result,
    input  out_flags, out_sub
  );

  modport slave (
    input  in_valid, in_sub, in_s, in_carry,
    input  in_overflow, out_ready,
    output in_ready, out_valid, out_result,
    output out_flags, out_sub
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry FIFO producing {N,Z,C,V} and a sticky overflow.
// Define ALU_SATURATE_EN to store saturated results on signed overflow.
module alu_result_stage #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus,
  input  logic                clr_sticky,
  output logic                sticky_v
);

  typedef struct packed {
    logic             sub;
    logic             c;
    logic             v;
    logic [WIDTH-1:0] res;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     wr_data;
  entry_t     head;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       live;
  logic       push;
  logic       pop;

  // live keeps in_ready low until the first edge out of reset
  assign bus.in_ready  = live && (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_data     = '0;
    wr_data.sub = bus.in_sub;
    wr_data.c   = bus.in_carry;
    wr_data.v   = bus.in_overflow;
    wr_data.res = bus.in_s;
`ifdef ALU_SATURATE_EN
    if (bus.in_overflow) begin
      if (bus.in_s[WIDTH-1])
        wr_data.res = {1'b0, {(WIDTH-1){1'b1}}};
      else
        wr_data.res = {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live     <= 1'b0;
      count_q  <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      sticky_v <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      live    <= 1'b1;
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr] <= wr_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      // a new overflow beats a simultaneous clear
      if (push && bus.in_overflow)
        sticky_v <= 1'b1;
      else if (clr_sticky)
        sticky_v <= 1'b0;
    end
  end

  assign head = mem_q[rd_ptr];

  assign bus.out_result = head.res;
  assign bus.out_sub    = head.sub;
  assign bus.out_flags  = {head.res[WIDTH-1],
                           head.res == '0,
                           head.c, head.v};

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_alu_result_stage;
  localparam int W    = 4;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic clk = 1'b0;
  logic rst_n;
  logic clr_sticky;
  logic sticky_v;

  alu_result_stage_if #(.WIDTH(W)) bus ();

  alu_result_stage #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .sticky_v   (sticky_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    bit sub;
    bit c;
    bit v;
  } exp_t;

  exp_t q[$];
  bit   m_sticky;
  bit   m_started;
  bit   last_push;
  int   n_vec;
  int   n_err;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  // Behave like an ideal W-bit adder/subtractor feeding the stage
  task automatic set_op(bit sub, int a, int b, bit valid);
    int sr;
    int s;
    bit c;
    if (sub) begin
      s  = (a - b + MOD) % MOD;
      c  = (a >= b);
      sr = to_signed(a) - to_signed(b);
    end else begin
      s  = (a + b) % MOD;
      c  = (a + b) >= MOD;
      sr = to_signed(a) + to_signed(b);
    end
    bus.in_sub      = sub;
    bus.in_s        = W'(s);
    bus.in_carry    = c;
    bus.in_overflow = (sr > HALF - 1) || (sr < -HALF);
    bus.in_valid    = valid;
  endtask

  function automatic exp_t mk_entry();
    exp_t e;
    e.sub = bus.in_sub;
    e.c   = bus.in_carry;
    e.v   = bus.in_overflow;
    e.res = int'(bus.in_s);
`ifdef ALU_SATURATE_EN
    if (e.v)
      e.res = (e.res >= HALF) ? HALF - 1 : HALF;
`endif
    return e;
  endfunction

  task automatic check_state(string tag);
    int   fl;
    exp_t h;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    chk({tag, ".in_ready"}, 32'(bus.in_ready),
        32'(m_started && q.size() < 2));
    chk({tag, ".sticky_v"}, 32'(sticky_v), 32'(m_sticky));
    if (q.size() != 0) begin
      h  = q[0];
      fl = ((h.res >= HALF) << 3) | ((h.res == 0) << 2) | (h.c << 1) | h.v;
      chk({tag, ".out_result"}, 32'(bus.out_result), 32'(h.res));
      chk({tag, ".out_flags"}, 32'(bus.out_flags), 32'(fl));
      chk({tag, ".out_sub"}, 32'(bus.out_sub), 32'(h.sub));
    end
  endtask

  task automatic cyc(string tag);
    bit   push;
    bit   pop;
    bit   rst_ok;
    exp_t e;
    rst_ok = rst_n;
    push = rst_ok && bus.in_valid && m_started && q.size() < 2;
    pop  = rst_ok && bus.out_ready && q.size() != 0;
    e    = mk_entry();
    @(posedge clk);
    if (rst_ok) begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      if (push && e.v) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
      m_started = 1'b1;
    end
    last_push = push;
    #1;
    check_state(tag);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    m_sticky     = 0;
    m_started    = 0;
    rst_n        = 1'b0;
    clr_sticky   = 1'b0;
    bus.out_ready = 1'b0;
    set_op(0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;
    cyc("first_edge");

    // basic add / overflow / subtract results
    bus.out_ready = 1'b1;
    set_op(0, 3, 4, 1);
    cyc("add_3_4");
    chk("add_3_4.res", 32'(bus.out_result), 32'h7);
    chk("add_3_4.flags", 32'(bus.out_flags), 32'h0);
    set_op(0, 7, 1, 1);
    cyc("add_7_1");
`ifdef ALU_SATURATE_EN
    chk("add_7_1.res", 32'(bus.out_result), 32'h7);
    chk("add_7_1.flags", 32'(bus.out_flags), 32'h1);
`else
    chk("add_7_1.res", 32'(bus.out_result), 32'h8);
    chk("add_7_1.flags", 32'(bus.out_flags), 32'h9);
`endif
    chk("add_7_1.sticky", 32'(sticky_v), 32'h1);
    set_op(1, 5, 5, 1);
    cyc("sub_5_5");
    chk("sub_5_5.flags", 32'(bus.out_flags), 32'h6);
    chk("sub_5_5.sub", 32'(bus.out_sub), 32'h1);
    bus.in_valid = 1'b0;
    cyc("drain");

    // back-pressure: A and B stored, C waits upstream
    bus.out_ready = 1'b0;
    set_op(0, 1, 1, 1);
    cyc("bp_A");
    set_op(1, 9, 2, 1);
    cyc("bp_B");
    set_op(0, 12, 6, 1);
    cyc("bp_C");
    chk("bp_full.in_ready", 32'(bus.in_ready), 32'h0);
    cyc("bp_hold");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc("bp_release");
      if (last_push) bus.in_valid = 1'b0;
    end

    // steady push+pop at count 1
    bus.out_ready = 1'b0;
    set_op(0, 2, 2, 1);
    cyc("pp_fill");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_op($urandom_range(0, 1), $urandom_range(0, MOD - 1),
             $urandom_range(0, MOD - 1), 1);
      cyc("pp_loop");
      chk("pp_loop.count1", 32'({bus.out_valid, bus.in_ready}), 32'h3);
    end
    clr_sticky = 1'b1;
    set_op(0, 7, 1, 1);
    cyc("set_beats_clr");
    chk("set_beats_clr.sticky", 32'(sticky_v), 32'h1);
    bus.in_valid = 1'b0;
    cyc("clr_only");
    chk("clr_only.sticky", 32'(sticky_v), 32'h0);
    clr_sticky = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_op($urandom_range(0, 1), $urandom_range(0, MOD - 1),
             $urandom_range(0, MOD - 1), $urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clr_sticky    = ($urandom_range(0, 7) == 0);
      cyc("rand");
    end
    clr_sticky = 1'b0;

    // asynchronous reset with two entries stored
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    repeat (3) cyc("pre_rst_drain");
    bus.out_ready = 1'b0;
    set_op(0, 7, 1, 1);
    cyc("rst_fill1");
    set_op(0, 2, 3, 1);
    cyc("rst_fill2");
    chk("rst_fill2.full", 32'(bus.in_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_sticky  = 1'b0;
    m_started = 1'b0;
    check_state("async_rst");
    set_op(0, 4, 1, 1);
    cyc("in_rst");
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc("rst_release");
    chk("rst_release.empty", 32'(bus.out_valid), 32'h0);
    cyc("first_accept");
    chk("first_accept.res", 32'(bus.out_result), 32'h5);
    bus.in_valid = 1'b0;
    cyc("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
